reg_file_hilo: RTL
==================

// Module: reg_file_hilo
// PURPOSE
//  Architectural register file for the single-cycle datapath: 32 x 32-bit GPRs plus a HI/LO pair.
//  Sits directly upstream of the ALU (rd1/rd2 drive ALU operands a/b) and closes the loop at writeback.
//  Writeback carries ALU/memory results into GPRs; the 64-bit multiply product (or {remainder,quotient}) goes into HI/LO.
//  Reads are combinational; all state updates on the rising clock edge.
// PARAMETERS
//  DATA_W     32  GPR and HI/LO width
//  ADDR_W     5   register address width; NUM_REGS = 2**ADDR_W
//  WR_BYPASS  1   1: same-cycle write data forwarded to read ports; 0: reads see pre-edge contents only
// PORTS
//  clk      in   1         rising-edge clock
//  rst_n    in   1         asynchronous, active-low reset
//  ra1      in   ADDR_W    read address, port 1 (rs)
//  ra2      in   ADDR_W    read address, port 2 (rt)
//  rd1      out  DATA_W    read data, port 1 -> ALU a
//  rd2      out  DATA_W    read data, port 2 -> ALU b
//  we       in   1         GPR write enable
//  wa       in   ADDR_W    GPR write address
//  wd       in   DATA_W    GPR write data (ALU out / load data)
//  hilo_we  in   1         HI/LO write enable
//  hilo_wd  in   2*DATA_W  {HI,LO} write data (multiplier product)
//  hi       out  DATA_W    HI register contents
//  lo       out  DATA_W    LO register contents
// BEHAVIOUR
//  - Reset: rst_n low asynchronously clears all GPRs, HI and LO to 0 -> rd1, rd2, hi, lo read 0 while rst_n is low.
//  - Reset mid-cycle: clears state immediately; a write pending that cycle is lost.
//  - First active edge after rst_n rises performs normal writes.
//  - GPR write: on posedge clk with we=1 and wa!=0, reg[wa] <= wd. Write latency 1 edge.
//  - R0: reads of address 0 always return 0. Writes to address 0 are discarded; no bypass for wa=0.
//  - Read: rdN = (raN==0) ? 0 : reg[raN]; purely combinational, 0-cycle latency.
//  - Bypass (WR_BYPASS=1): if we=1, wa==raN, wa!=0 and rst_n=1, then rdN = wd in the same cycle.
//  - Both ports bypass independently; ra1==ra2 is legal and returns identical data.
//  - HI/LO: on posedge clk with hilo_we=1, {hi,lo} <= hilo_wd. hi/lo are registered outputs; no bypass. Latency 1 edge.
//  - we and hilo_we asserted together: both updates occur; they are fully independent.
//  - X on wa/wd with we=0 has no effect on state.
//  - No handshake: every enabled write is accepted every cycle; no back-pressure.
// CONFIGURATION
//  RF_DEBUG_PORT_EN defined:
//    - adds ports dbg_ra (in, ADDR_W) and dbg_rd (out, DATA_W), a third combinational read port for the test bench/monitor.
//    - Same r0 rule as the main ports; never bypassed (always shows committed contents).
//  RF_DEBUG_PORT_EN undefined: the ports and logic are absent; functional behaviour is otherwise identical.
// STRUCTURE
//  - Package regfile_pkg:
//    - DATA_W and ADDR_W defaults; NUM_REGS; REG_ZERO = 5'd0.
//    - typedef data_t [DATA_W-1:0], addr_t [ADDR_W-1:0], hilo_t [2*DATA_W-1:0].
//    - Shared by ALU and decode.
//  - Sub-module hilo_reg: 64-bit enable register with async active-low clear, outputs hi/lo.
//  - GPR array, read muxes and bypass logic stay in the top level.
// TESTING
//  1 Reset: write r5=32'hDEADBEEF, assert rst_n low mid-cycle -> rd1(ra1=5)=0, hi=lo=0 immediately; state stays 0 after release.
//  2 Write/read: we=1, wa=7, wd=32'h1234_5678, edge; ra1=7, ra2=7 -> rd1=rd2=32'h1234_5678.
//  3 Zero reg: we=1, wa=0, wd=32'hFFFF_FFFF, ra1=0 -> rd1=0 both same cycle and after edge.
//  4 Bypass: r3 holds 32'h11; we=1, wa=3, wd=32'h22, ra1=3 -> rd1=32'h22 pre-edge (WR_BYPASS=1), 32'h11 pre-edge (WR_BYPASS=0).
//  5 HI/LO: hilo_we=1, hilo_wd=64'h0000_0001_8000_0000 together with we=1, wa=9, wd=5, edge -> hi=1, lo=32'h8000_0000, r9=5.
//  6 Debug (RF_DEBUG_PORT_EN): r31=32'hCAFE; we=1, wa=31, wd=1; dbg_ra=31 -> dbg_rd=32'hCAFE pre-edge, 1 after edge.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared register-file definitions used by the register file, ALU and decode.
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int NUM_REGS   = 2 ** DEF_ADDR_W;

  typedef logic [DEF_DATA_W-1:0]   data_t;
  typedef logic [DEF_ADDR_W-1:0]   addr_t;
  typedef logic [2*DEF_DATA_W-1:0] hilo_t;

  localparam addr_t REG_ZERO = 5'd0;

endpackage

// File: rtl/hilo_reg.sv
// HI/LO pair: a 2*DATA_W enable register loaded with the multiplier product
// (or {remainder,quotient}); asynchronously cleared by rst_n.
module hilo_reg
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [2*DATA_W-1:0] d,
  output logic [DATA_W-1:0]   hi,
  output logic [DATA_W-1:0]   lo
);

  // Load {hi,lo} on enabled edges; clear immediately on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi <= '0;
      lo <= '0;
    end else if (en) begin
      hi <= d[2*DATA_W-1:DATA_W];
      lo <= d[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/reg_file_hilo.sv
// Architectural register file: 2**ADDR_W GPRs (r0 hard-wired to zero) with two
// combinational read ports, optional same-cycle write forwarding, and a HI/LO pair.
// Optional feature: define RF_DEBUG_PORT_EN to add a third, never-forwarded
// read port (dbg_ra/dbg_rd) showing committed contents.
module reg_file_hilo
  import regfile_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int WR_BYPASS = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_W-1:0]   ra1,
  input  logic [ADDR_W-1:0]   ra2,
  output logic [DATA_W-1:0]   rd1,
  output logic [DATA_W-1:0]   rd2,
  input  logic                we,
  input  logic [ADDR_W-1:0]   wa,
  input  logic [DATA_W-1:0]   wd,
  input  logic                hilo_we,
  input  logic [2*DATA_W-1:0] hilo_wd,
  output logic [DATA_W-1:0]   hi,
  output logic [DATA_W-1:0]   lo
`ifdef RF_DEBUG_PORT_EN
  ,
  input  logic [ADDR_W-1:0]   dbg_ra,
  output logic [DATA_W-1:0]   dbg_rd
`endif
);

  localparam int                RF_DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ADDR_R0  = '0;

  logic [DATA_W-1:0] regs [RF_DEPTH];
  logic              wr_gpr;
  logic              byp_en;

  // r0 is never written, so a write to it is simply dropped here.
  assign wr_gpr = we && (wa != ADDR_R0);

  // Forwarding is suppressed during reset so reads show the cleared state.
  assign byp_en = (WR_BYPASS != 0) && wr_gpr && rst_n;

  // GPR array: cleared asynchronously, written on the rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RF_DEPTH; i++) regs[i] <= '0;
    end else if (wr_gpr) begin
      regs[wa] <= wd;
    end
  end

  // Read port 1: r0 reads zero, otherwise stored value or forwarded write data.
  always_comb begin
    rd1 = (ra1 == ADDR_R0) ? '0 : regs[ra1];
    if (byp_en && (wa == ra1)) rd1 = wd;
  end

  // Read port 2: same rule as port 1, forwarded independently.
  always_comb begin
    rd2 = (ra2 == ADDR_R0) ? '0 : regs[ra2];
    if (byp_en && (wa == ra2)) rd2 = wd;
  end

`ifdef RF_DEBUG_PORT_EN
  // Debug read port: committed contents only, no forwarding.
  always_comb begin
    dbg_rd = (dbg_ra == ADDR_R0) ? '0 : regs[dbg_ra];
  end
`endif

  hilo_reg #(
    .DATA_W (DATA_W)
  ) u_hilo (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (hilo_we),
    .d     (hilo_wd),
    .hi    (hi),
    .lo    (lo)
  );

endmodule
